// File: rtl/rename_register_file_pkg.sv
// Shared widths, derived sizes and the rename snapshot record (per-register tag array plus busy vector).
package rename_register_file_pkg;

  localparam int XLEN_DEF           = 32;
  localparam int REG_ADDR_WIDTH_DEF = 5;
  localparam int ROB_WIDTH_DEF      = 4;
  localparam int CKPT_WIDTH_DEF     = 2;

  localparam int NUM_REGS   = 2 ** REG_ADDR_WIDTH_DEF;
  localparam int CKPT_DEPTH = 2 ** CKPT_WIDTH_DEF;

  typedef logic [ROB_WIDTH_DEF-1:0] rob_tag_t;

  typedef struct packed {
    rob_tag_t [NUM_REGS-1:0] tag;
    logic     [NUM_REGS-1:0] busy;
  } snap_t;

  // Retire a ROB tag from a rename map: every busy register waiting on it becomes ready.
  function automatic snap_t snap_commit(input snap_t s, input logic commit_vld,
                                        input rob_tag_t commit_tag);
    snap_t r;
    r = s;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (commit_vld && s.busy[i] && (s.tag[i] == commit_tag)) r.busy[i] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/rename_ckpt_fifo.sv
// Circular FIFO of rename-map snapshots taken at branches; oldest entry at head, next free at tail.
// Live entries are kept commit-coherent so a restore never resurrects an already retired producer.
module rename_ckpt_fifo
  import rename_register_file_pkg::*;
#(
  parameter int CKPT_WIDTH = CKPT_WIDTH_DEF
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  clear_i,
  input  logic                  take_i,
  input  snap_t                 snap_i,
  input  logic                  release_i,
  input  logic                  restore_i,
  input  logic [CKPT_WIDTH-1:0] restore_id_i,
  input  logic                  commit_vld_i,
  input  rob_tag_t              commit_tag_i,
  output logic                  restore_ok_o,
  output snap_t                 restore_snap_o,
  output logic [CKPT_WIDTH-1:0] tail_o,
  output logic                  full_o
);

  localparam int DEPTH = 2 ** CKPT_WIDTH;
  localparam logic [CKPT_WIDTH:0] DEPTH_CNT = (CKPT_WIDTH+1)'(DEPTH);

  logic [CKPT_WIDTH-1:0] head_q, head_d;
  logic [CKPT_WIDTH-1:0] tail_q, tail_d;
  logic [CKPT_WIDTH:0]   count_q, count_d;
  snap_t                 snap_q [DEPTH];
  snap_t                 snap_d [DEPTH];

  logic                  do_release;
  logic                  do_take;
  logic [CKPT_WIDTH-1:0] head_rel;
  logic [CKPT_WIDTH:0]   count_rel;
  logic [CKPT_WIDTH-1:0] restore_dist;

  assign full_o     = (count_q == DEPTH_CNT);
  assign tail_o     = tail_q;
  assign do_release = release_i && (count_q != '0);
  assign head_rel   = head_q + CKPT_WIDTH'(do_release);
  assign count_rel  = count_q - (CKPT_WIDTH+1)'(do_release);

  // Liveness is judged after this cycle's release has retired the oldest entry.
  assign restore_dist   = restore_id_i - head_rel;
  assign restore_ok_o   = restore_i && ({1'b0, restore_dist} < count_rel);
  assign restore_snap_o = snap_commit(snap_q[restore_id_i], commit_vld_i, commit_tag_i);
  assign do_take        = take_i && !full_o && !clear_i && !restore_ok_o;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (restore_ok_o) begin
      head_d  = head_rel;
      tail_d  = restore_id_i + CKPT_WIDTH'(1);
      count_d = {1'b0, restore_dist} + (CKPT_WIDTH+1)'(1);
    end else begin
      head_d  = head_rel;
      tail_d  = tail_q + CKPT_WIDTH'(do_take);
      count_d = count_rel + (CKPT_WIDTH+1)'(do_take);
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      snap_d[i] = snap_commit(snap_q[i], commit_vld_i, commit_tag_i);
      if (do_take && (tail_q == CKPT_WIDTH'(i))) snap_d[i] = snap_i;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) snap_q[i] <= '0;
    end else if (rdy_in) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) snap_q[i] <= snap_d[i];
    end
  end

endmodule

// File: rtl/rename_register_file.sv
// Architectural register file with rename map (tag/busy per register), commit bypass on reads
// and branch checkpoints for single-cycle mispredict recovery.
module rename_register_file
  import rename_register_file_pkg::*;
#(
  parameter int XLEN           = XLEN_DEF,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int ROB_WIDTH      = ROB_WIDTH_DEF,
  parameter int CKPT_WIDTH     = CKPT_WIDTH_DEF
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      clear_signal,
  input  logic                      issue_signal,
  input  logic [REG_ADDR_WIDTH-1:0] rs_id_1,
  input  logic [REG_ADDR_WIDTH-1:0] rs_id_2,
  output logic [XLEN-1:0]           rs_value_1,
  output logic [XLEN-1:0]           rs_value_2,
  output logic [ROB_WIDTH-1:0]      rs_tag_1,
  output logic [ROB_WIDTH-1:0]      rs_tag_2,
  output logic                      rs_valid_1,
  output logic                      rs_valid_2,
  input  logic [REG_ADDR_WIDTH-1:0] rd_id,
  input  logic [ROB_WIDTH-1:0]      rd_tag,
  input  logic                      ckpt_signal,
  output logic [CKPT_WIDTH-1:0]     ckpt_id,
  output logic                      ckpt_full,
  input  logic                      release_signal,
  input  logic                      restore_signal,
  input  logic [CKPT_WIDTH-1:0]     restore_ckpt_id,
  input  logic                      commit_signal,
  input  logic [XLEN-1:0]           commit_rd_value,
  input  logic [ROB_WIDTH-1:0]      commit_rd_tag
);

  // The snapshot record is shaped by the package widths, so the map-related widths must agree.
  if (REG_ADDR_WIDTH != REG_ADDR_WIDTH_DEF || ROB_WIDTH != ROB_WIDTH_DEF) begin : g_width_guard
    $error("rename_register_file: REG_ADDR_WIDTH/ROB_WIDTH must match the package widths");
  end

  typedef struct packed {
    logic [XLEN-1:0] value;
    rob_tag_t        tag;
    logic            valid;
  } rd_res_t;

  logic [XLEN-1:0]     value_q [NUM_REGS];
  logic [XLEN-1:0]     value_d [NUM_REGS];
  snap_t               main_q, main_d;
  snap_t               committed, renamed, restore_snap;
  logic                restore_ok;
  logic                issue_rd;
  logic [NUM_REGS-1:0] commit_hit;
  rd_res_t             rd1, rd2;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      commit_hit[i] = commit_signal && main_q.busy[i] && (main_q.tag[i] == commit_rd_tag);
    end
  end

  assign issue_rd = issue_signal && (rd_id != '0);

  always_comb begin
    committed      = main_q;
    committed.busy = main_q.busy & ~commit_hit;
  end

  // Rename lands on top of the commit, so a same-cycle commit to rd still leaves rd busy.
  always_comb begin
    renamed = committed;
    if (issue_rd) begin
      renamed.tag[rd_id]  = rd_tag;
      renamed.busy[rd_id] = 1'b1;
    end
  end

  always_comb begin
    main_d = renamed;
    if (clear_signal) begin
      main_d      = committed;
      main_d.busy = '0;
    end else if (restore_ok) begin
      main_d = restore_snap;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      value_d[i] = commit_hit[i] ? commit_rd_value : value_q[i];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      main_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) value_q[i] <= '0;
    end else if (rdy_in) begin
      main_q <= main_d;
      for (int i = 0; i < NUM_REGS; i++) value_q[i] <= value_d[i];
    end
  end

  function automatic rd_res_t read_port(input logic [REG_ADDR_WIDTH-1:0] id);
    rd_res_t r;
    r.value = value_q[id];
    r.tag   = main_q.tag[id];
    r.valid = !main_q.busy[id];
    if (id == '0) begin
      r.value = '0;
      r.tag   = '0;
      r.valid = 1'b1;
    end else if (commit_hit[id]) begin
      r.value = commit_rd_value;
      r.valid = 1'b1;
    end
    return r;
  endfunction

  assign rd1        = read_port(rs_id_1);
  assign rd2        = read_port(rs_id_2);
  assign rs_value_1 = rd1.value;
  assign rs_tag_1   = rd1.tag;
  assign rs_valid_1 = rd1.valid;
  assign rs_value_2 = rd2.value;
  assign rs_tag_2   = rd2.tag;
  assign rs_valid_2 = rd2.valid;

  rename_ckpt_fifo #(
    .CKPT_WIDTH(CKPT_WIDTH)
  ) u_ckpt (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .clear_i       (clear_signal),
    .take_i        (issue_signal && ckpt_signal),
    .snap_i        (renamed),
    .release_i     (release_signal),
    .restore_i     (restore_signal),
    .restore_id_i  (restore_ckpt_id),
    .commit_vld_i  (commit_signal),
    .commit_tag_i  (commit_rd_tag),
    .restore_ok_o  (restore_ok),
    .restore_snap_o(restore_snap),
    .tail_o        (ckpt_id),
    .full_o        (ckpt_full)
  );

endmodule

// File: tb/tb_rename_register_file.sv
// Scoreboarded random bench for rename_register_file against a queue-based checkpoint model.
module tb_rename_register_file;

  localparam int NR = 32;
  localparam int D  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_in = 1'b1, rdy_in = 1'b1, clear_signal = 1'b0, issue_signal = 1'b0;
  logic [4:0]  rs_id_1 = '0, rs_id_2 = '0, rd_id = '0;
  logic [31:0] rs_value_1, rs_value_2;
  logic [3:0]  rs_tag_1, rs_tag_2;
  logic        rs_valid_1, rs_valid_2;
  logic [3:0]  rd_tag = '0;
  logic        ckpt_signal = 1'b0;
  logic [1:0]  ckpt_id;
  logic        ckpt_full;
  logic        release_signal = 1'b0, restore_signal = 1'b0;
  logic [1:0]  restore_ckpt_id = '0;
  logic        commit_signal = 1'b0;
  logic [31:0] commit_rd_value = '0;
  logic [3:0]  commit_rd_tag = '0;

  rename_register_file #(.XLEN(32), .REG_ADDR_WIDTH(5), .ROB_WIDTH(4), .CKPT_WIDTH(2)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .clear_signal(clear_signal),
    .issue_signal(issue_signal), .rs_id_1(rs_id_1), .rs_id_2(rs_id_2),
    .rs_value_1(rs_value_1), .rs_value_2(rs_value_2), .rs_tag_1(rs_tag_1), .rs_tag_2(rs_tag_2),
    .rs_valid_1(rs_valid_1), .rs_valid_2(rs_valid_2), .rd_id(rd_id), .rd_tag(rd_tag),
    .ckpt_signal(ckpt_signal), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full),
    .release_signal(release_signal), .restore_signal(restore_signal),
    .restore_ckpt_id(restore_ckpt_id), .commit_signal(commit_signal),
    .commit_rd_value(commit_rd_value), .commit_rd_tag(commit_rd_tag)
  );

  typedef struct {
    bit rst, rdy, clr, iss, ck, rel, rs, cm;
    int a1, a2, rd, rt, rsid, ct;
    logic [31:0] cv;
  } stim_t;

  typedef struct {
    bit          chk;
    logic [31:0] v1, v2;
    logic [3:0]  t1, t2;
    logic        vl1, vl2;
    logic [1:0]  cid;
    logic        full;
  } exp_t;

  typedef struct packed {
    int               id;
    bit [NR-1:0][3:0] tag;
    bit [NR-1:0]      busy;
  } ck_t;

  exp_t exp_q[$];

  logic [31:0]      m_val [NR];
  bit [NR-1:0][3:0] m_tag;
  bit [NR-1:0]      m_busy;
  ck_t              ck_q[$];
  int               m_tail;
  bit               known = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  function automatic void check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 0, rdy: 1, clr: 0, iss: 0, ck: 0, rel: 0, rs: 0, cm: 0,
          a1: 0, a2: 0, rd: 0, rt: 0, rsid: 0, ct: 0, cv: '0};
    return s;
  endfunction

  function automatic void model_read(input int id, input stim_t s, output logic [31:0] v,
                                     output logic [3:0] t, output logic vl);
    if (id == 0) begin
      v = '0; t = '0; vl = 1'b1;
    end else if (s.cm && m_busy[id] && (m_tag[id] == s.ct[3:0])) begin
      v = s.cv; t = m_tag[id]; vl = 1'b1;
    end else begin
      v = m_val[id]; t = m_tag[id]; vl = !m_busy[id];
    end
  endfunction

  function automatic void model_step(input stim_t s);
    bit  full_before;
    int  found;
    ck_t c;
    if (s.rst) begin
      for (int i = 0; i < NR; i++) m_val[i] = '0;
      m_tag = '0; m_busy = '0; ck_q.delete(); m_tail = 0;
      return;
    end
    if (!s.rdy) return;
    full_before = (ck_q.size() == D);
    if (s.cm) begin
      for (int i = 1; i < NR; i++)
        if (m_busy[i] && m_tag[i] == s.ct[3:0]) begin m_val[i] = s.cv; m_busy[i] = 1'b0; end
      for (int k = 0; k < ck_q.size(); k++) begin
        c = ck_q[k];
        for (int i = 0; i < NR; i++)
          if (c.busy[i] && c.tag[i] == s.ct[3:0]) c.busy[i] = 1'b0;
        ck_q[k] = c;
      end
    end
    if (s.clr) begin
      m_busy = '0; ck_q.delete(); m_tail = 0;
      return;
    end
    if (s.rel && ck_q.size() > 0) void'(ck_q.pop_front());
    found = -1;
    if (s.rs) for (int k = 0; k < ck_q.size(); k++) if (ck_q[k].id == s.rsid) found = k;
    if (found >= 0) begin
      m_tag  = ck_q[found].tag;
      m_busy = ck_q[found].busy;
      while (ck_q.size() > found + 1) void'(ck_q.pop_back());
      m_tail = (s.rsid + 1) % D;
      return;
    end
    if (s.iss && s.rd != 0) begin m_tag[s.rd] = s.rt[3:0]; m_busy[s.rd] = 1'b1; end
    if (s.iss && s.ck && !full_before) begin
      c.id = m_tail; c.tag = m_tag; c.busy = m_busy;
      ck_q.push_back(c);
      m_tail = (m_tail + 1) % D;
    end
  endfunction

  task automatic cyc(input stim_t s);
    exp_t e;
    @(posedge clk); #1;
    rst_in = s.rst; rdy_in = s.rdy; clear_signal = s.clr; issue_signal = s.iss;
    rs_id_1 = s.a1[4:0]; rs_id_2 = s.a2[4:0]; rd_id = s.rd[4:0]; rd_tag = s.rt[3:0];
    ckpt_signal = s.ck; release_signal = s.rel; restore_signal = s.rs;
    restore_ckpt_id = s.rsid[1:0]; commit_signal = s.cm; commit_rd_tag = s.ct[3:0];
    commit_rd_value = s.cv;
    e.chk = known;
    model_read(s.a1, s, e.v1, e.t1, e.vl1);
    model_read(s.a2, s, e.v2, e.t2, e.vl2);
    e.cid  = m_tail[1:0];
    e.full = (ck_q.size() == D);
    exp_q.push_back(e);
    model_step(s);
    if (s.rst) known = 1'b1;
  endtask

  function automatic stim_t rnd();
    stim_t s;
    s = idle();
    s.rst  = ($urandom_range(0, 199) == 0);
    s.rdy  = ($urandom_range(0, 9) != 0);
    s.clr  = ($urandom_range(0, 59) == 0);
    s.iss  = ($urandom_range(0, 9) < 6);
    s.ck   = ($urandom_range(0, 9) < 3);
    s.rel  = ($urandom_range(0, 9) < 2);
    s.rs   = ($urandom_range(0, 19) == 0);
    s.rsid = $urandom_range(0, 3);
    s.cm   = ($urandom_range(0, 9) < 5);
    s.a1   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
    s.a2   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
    s.rd   = $urandom_range(0, 7);
    s.rt   = $urandom_range(0, 15);
    s.ct   = $urandom_range(0, 15);
    s.cv   = $urandom;
    return s;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk) begin
          check("sb_rs_value_1", rs_value_1, e.v1);
          check("sb_rs_tag_1", 32'(rs_tag_1), 32'(e.t1));
          check("sb_rs_valid_1", 32'(rs_valid_1), 32'(e.vl1));
          check("sb_rs_value_2", rs_value_2, e.v2);
          check("sb_rs_tag_2", 32'(rs_tag_2), 32'(e.t2));
          check("sb_rs_valid_2", 32'(rs_valid_2), 32'(e.vl2));
          check("sb_ckpt_id", 32'(ckpt_id), 32'(e.cid));
          check("sb_ckpt_full", 32'(ckpt_full), 32'(e.full));
        end
      end
    end
  end

  initial begin : driver
    stim_t s;
    s = idle(); s.rst = 1; cyc(s);
    s = idle(); s.a1 = 9; cyc(s); #1;
    check("rst_valid", 32'(rs_valid_1), 32'd1);
    check("rst_value", rs_value_1, 32'd0);
    check("rst_ckpt_id", 32'(ckpt_id), 32'd0);
    check("rst_full", 32'(ckpt_full), 32'd0);

    s = idle(); s.iss = 1; s.rd = 5; s.rt = 3; cyc(s);
    s = idle(); s.a1 = 5; cyc(s); #1;
    check("issue_busy", 32'(rs_valid_1), 32'd0);
    check("issue_tag", 32'(rs_tag_1), 32'd3);
    s = idle(); s.a1 = 5; s.cm = 1; s.ct = 3; s.cv = 32'hAA; cyc(s); #1;
    check("bypass_value", rs_value_1, 32'hAA);
    check("bypass_valid", 32'(rs_valid_1), 32'd1);

    s = idle(); s.iss = 1; s.rd = 0; s.rt = 2; cyc(s);
    s = idle(); s.a2 = 0; cyc(s); #1;
    check("r0_value", rs_value_2, 32'd0);
    check("r0_valid", 32'(rs_valid_2), 32'd1);

    s = idle(); s.rst = 1; cyc(s);
    s = idle(); s.iss = 1; s.rd = 7; s.rt = 1; s.ck = 1; cyc(s); #1;
    check("take_id0", 32'(ckpt_id), 32'd0);
    s = idle(); s.iss = 1; s.rd = 7; s.rt = 2; cyc(s);
    s = idle(); s.rs = 1; s.rsid = 0; cyc(s);
    s = idle(); s.a1 = 7; cyc(s); #1;
    check("restore_tag", 32'(rs_tag_1), 32'd1);
    check("restore_busy", 32'(rs_valid_1), 32'd0);
    check("restore_tail", 32'(ckpt_id), 32'd1);

    s = idle(); s.iss = 1; s.rd = 3; s.rt = 5; s.ck = 1; cyc(s);
    s = idle(); s.cm = 1; s.ct = 1; s.cv = 32'h55; cyc(s);
    s = idle(); s.rs = 1; s.rsid = 1; cyc(s);
    s = idle(); s.a1 = 7; cyc(s); #1;
    check("restore_commit_valid", 32'(rs_valid_1), 32'd1);
    check("restore_commit_value", rs_value_1, 32'h55);
    check("restore_commit_tail", 32'(ckpt_id), 32'd2);

    s = idle(); s.rst = 1; cyc(s);
    for (int i = 0; i < D; i++) begin
      s = idle(); s.iss = 1; s.rd = i + 1; s.rt = i; s.ck = 1; cyc(s);
    end
    s = idle(); s.iss = 1; s.rd = 9; s.rt = 9; s.ck = 1; cyc(s); #1;
    check("full_set", 32'(ckpt_full), 32'd1);
    s = idle(); cyc(s); #1;
    check("full_ignored", 32'(ckpt_full), 32'd1);
    check("full_tail", 32'(ckpt_id), 32'd0);
    s = idle(); s.rel = 1; cyc(s);
    s = idle(); cyc(s); #1;
    check("release_full", 32'(ckpt_full), 32'd0);
    check("release_id_wrap", 32'(ckpt_id), 32'd0);

    s = idle(); s.rst = 1; cyc(s);
    s = idle(); s.iss = 1; s.rd = 1; s.rt = 9; cyc(s);
    s = idle(); s.cm = 1; s.ct = 9; s.cv = 32'h11; cyc(s);
    s = idle(); s.iss = 1; s.rd = 1; s.rt = 1; s.ck = 1; cyc(s);
    s = idle(); s.iss = 1; s.rd = 2; s.rt = 2; s.ck = 1; cyc(s);
    s = idle(); s.iss = 1; s.rd = 3; s.rt = 3; cyc(s);
    s = idle(); s.clr = 1; cyc(s);
    s = idle(); s.a1 = 1; s.a2 = 3; cyc(s); #1;
    check("clear_valid1", 32'(rs_valid_1), 32'd1);
    check("clear_value1", rs_value_1, 32'h11);
    check("clear_valid3", 32'(rs_valid_2), 32'd1);
    check("clear_ckpt_id", 32'(ckpt_id), 32'd0);
    check("clear_full", 32'(ckpt_full), 32'd0);

    for (int n = 0; n < 3000; n++) cyc(rnd());
    s = idle(); cyc(s);
    @(negedge clk); #1;
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rename_register_file.md
RENAME_REGISTER_FILE -- requirements
Module: rename_register_file

Interface
REQ-001 SHALL have parameters: XLEN, default 32, data width; REG_ADDR_WIDTH, default 5, register index width (NUM_REGS = 2^REG_ADDR_WIDTH); ROB_WIDTH, default 4, ROB tag width; CKPT_WIDTH, default 2, checkpoint index width (CKPT_DEPTH = 2^CKPT_WIDTH).
REQ-002 SHALL use one clock, clk_in; reset rst_in is synchronous and active-high; rdy_in low freezes all state.
REQ-003 Ports (name direction width meaning):
- clk_in in 1 clock; rst_in in 1 sync active-high reset; rdy_in in 1 global enable
- clear_signal in 1 full pipeline flush
- issue_signal in 1 rename one instruction; rs_id_1/rs_id_2 in REG_ADDR_WIDTH source indices
- rs_value_1/2 out XLEN; rs_tag_1/2 out ROB_WIDTH; rs_valid_1/2 out 1 (1 = value ready)
- rd_id in REG_ADDR_WIDTH; rd_tag in ROB_WIDTH new producer tag for rd
- ckpt_signal in 1 take snapshot with this issue (branch); ckpt_id out CKPT_WIDTH index the snapshot will receive; ckpt_full out 1 no free snapshot
- release_signal in 1 oldest snapshot's branch resolved correct, free it
- restore_signal in 1 mispredict; restore_ckpt_id in CKPT_WIDTH snapshot to restore
- commit_signal in 1; commit_rd_value in XLEN; commit_rd_tag in ROB_WIDTH ROB commit

Function
REQ-004 Reads SHALL be combinational from current state; rs_valid=1 and rs_value=commit_rd_value when commit_signal and reg busy and tag equals commit_rd_tag (bypass), else stored value/tag/ready.
REQ-005 Register 0 SHALL always read value 0, valid 1; writes/renames to it ignored.
REQ-006 On issue_signal with rd_id!=0: tag[rd]<=rd_tag, busy[rd]<=1 next cycle; reads in the same cycle see pre-rename state.
REQ-007 On commit_signal: for every reg with busy=1 and tag==commit_rd_tag, value<=commit_rd_value and busy<=0.
REQ-008 Commit and issue to the same rd in one cycle: value SHALL be written, busy stays 1 with new rd_tag.
REQ-009 Checkpoints SHALL form a circular FIFO (head=oldest, tail=next free, count 0..CKPT_DEPTH); ckpt_id=tail; ckpt_full=(count==CKPT_DEPTH).
REQ-010 issue_signal&ckpt_signal&~ckpt_full: snapshot at tail SHALL hold tag/busy of all regs after this cycle's rename and commit; tail++ (wraps).
REQ-011 ckpt_signal while ckpt_full: snapshot SHALL NOT be taken, rename still performed; upstream must stall.
REQ-012 Commit SHALL also clear busy in every live snapshot entry whose tag matches commit_rd_tag.
REQ-013 release_signal with count>0: head++; with count==0 ignored.
REQ-014 restore_signal with restore_ckpt_id live: tag/busy<=snapshot contents with the same-cycle commit applied; tail<=restore_ckpt_id+1; values unchanged; same-cycle issue and ckpt dropped.
REQ-015 restore_signal with non-live id SHALL be ignored.
REQ-016 Same-cycle release and restore: release applied first, then restore only if id still live.
REQ-017 Same-cycle ckpt take and release: count unchanged, both pointers advance.
REQ-018 clear_signal (priority over issue/restore/release): all busy<=0, head=tail=count=0; values kept; same-cycle commit value still written.

Reset
REQ-019 rst_in SHALL set all values 0, tags 0, busy 0, head=tail=count=0; outputs: rs_valid 1, rs_value 0, ckpt_id 0, ckpt_full 0.
REQ-020 rst_in SHALL override rdy_in and every request, including mid-snapshot or mid-restore.

Structure
REQ-021 Shared package SHALL hold default widths, NUM_REGS/CKPT_DEPTH derivations and the snapshot record (tag array + busy vector).
REQ-022 One sub-module, rename_ckpt_fifo, SHALL hold snapshot storage, pointers, count, commit-clear and full flag.

Verification
REQ-023 Issue rd=5 tag=3; next cycle read rs1=5 -> valid 0, tag 3; commit tag 3 value 0xAA same cycle -> rs_value_1 0xAA, valid 1.
REQ-024 Issue rd=0 tag=2 -> reg 0 reads value 0, valid 1.
REQ-025 Issue rd=7 tag=1 with ckpt (id 0); issue rd=7 tag=2; restore id 0 -> reg 7 tag 1 busy 1, tail=1.
REQ-026 Take snapshot, commit tag 1, restore -> reg 7 valid 1 with committed value.
REQ-027 Take CKPT_DEPTH snapshots -> ckpt_full 1; further ckpt ignored; release -> ckpt_full 0, ckpt_id wraps to 0.
REQ-028 clear_signal with 3 busy regs and 2 snapshots -> all valid 1, ckpt_id 0, ckpt_full 0, values retained.
